// File: rtl/wm8978_pkg.sv
// Shared definitions for the WM8978 runtime volume/mute scheduler.
// Holds the output-volume register addresses, the scheduler state encoding,
// the volume ceiling, and two small helpers. The helpers compute the
// saturating level update and build the 16-bit I2C word for a write slot.
package wm8978_pkg;

    localparam logic [6:0] REG_LOUT1 = 7'd52;
    localparam logic [6:0] REG_ROUT1 = 7'd53;
    localparam logic [6:0] REG_LSPK  = 7'd54;
    localparam logic [6:0] REG_RSPK  = 7'd55;

    localparam logic [5:0] VOL_MAX = 6'd63;

    typedef enum logic [2:0] {
        ST_WAIT_CFG,
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_WAIT,
        ST_NEXT
    } state_t;

    // Saturating volume update. Simultaneous up and down cancel out.
    // The 7-bit sum catches overflow past 63 before it is truncated.
    function automatic logic [5:0] next_level(input logic [5:0] level,
                                              input logic [5:0] step,
                                              input logic       up,
                                              input logic       dn);
        logic [6:0] sum;
        sum        = {1'b0, level} + {1'b0, step};
        next_level = level;
        if (up && !dn)
            next_level = (sum > {1'b0, VOL_MAX}) ? VOL_MAX : sum[5:0];
        else if (dn && !up)
            next_level = (level < step) ? 6'd0 : level - step;
    endfunction

    // I2C word layout is {addr[6:0], upd, zc=0, mute, vol[5:0]}.
    // The odd slots are the right-channel registers (R53, R55). Each of
    // them carries the update bit, which latches the left/right pair.
    function automatic logic [15:0] reg_word(input logic [1:0] idx,
                                             input logic       mute,
                                             input logic [5:0] level);
        logic [6:0] addr;
        case (idx)
            2'd0:    addr = REG_LOUT1;
            2'd1:    addr = REG_ROUT1;
            2'd2:    addr = REG_LSPK;
            default: addr = REG_RSPK;
        endcase
        reg_word = {addr, idx[0], 1'b0, mute, level};
    endfunction

endpackage

// File: rtl/wm8978_vol_sched_if.sv
// Handshake between the volume scheduler and the shared I2C write driver.
//   i2c_exec : 1-cycle write request          (master -> slave)
//   i2c_data : {reg_addr[6:0], reg_val[8:0]}  (master -> slave)
//   i2c_done : 1-cycle write finished         (slave -> master)
//   i2c_ack  : 1 = codec NACK, valid with i2c_done (slave -> master)
interface wm8978_vol_sched_if;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic        i2c_ack;

    modport master (output i2c_exec, i2c_data, input  i2c_done, i2c_ack);
    modport slave  (input  i2c_exec, i2c_data, output i2c_done, i2c_ack);
endinterface

// File: rtl/wm8978_vol_sched.sv
// WM8978 runtime volume/mute scheduler.
// This block turns vol_up / vol_dn / mute_tgl pulses into ordered I2C writes
// to the headphone volume registers (R52/R53). When SPK_EN is set, it also
// writes the speaker volume registers (R54/R55). It waits for the power-up
// configuration to report done, then writes the committed level once.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cfg_done        : level, initial codec configuration complete
//   vol_up, vol_dn  : 1-cycle volume step requests
//   mute_tgl        : 1-cycle mute toggle request
//   bus (master)    : I2C driver handshake (exec/data out, done/ack in)
//   vol_level, mute : committed volume and mute state
//   busy            : a write sequence is in progress
//   err             : sticky, a write was still NACKed after MAX_RETRY retries
module wm8978_vol_sched
    import wm8978_pkg::*;
#(
    parameter logic [5:0] VOL_INIT  = 6'd40,
    parameter logic [5:0] VOL_STEP  = 6'd4,
    parameter logic [1:0] MAX_RETRY = 2'd3,
    parameter logic       SPK_EN    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_done,
    input  logic                       vol_up,
    input  logic                       vol_dn,
    input  logic                       mute_tgl,
    wm8978_vol_sched_if.master         bus,
    output logic [5:0]                 vol_level,
    output logic                       mute,
    output logic                       busy,
    output logic                       err
);

    localparam logic [1:0] LAST_IDX = SPK_EN ? 2'd3 : 2'd1;

    state_t     state, state_n;
    logic [1:0] idx;
    logic [1:0] retry_cnt;
    logic       pending;
    logic       req;

    // Control strobes from the next-state logic to the datapath registers.
    logic force_pend, clr_pend, idx_clr, idx_inc;
    logic ld_data, retry_clr, retry_inc, set_err;

    assign req = vol_up | vol_dn | mute_tgl;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
        state_n    = state;
        force_pend = 1'b0;
        clr_pend   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        ld_data    = 1'b0;
        retry_clr  = 1'b0;
        retry_inc  = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_WAIT_CFG: if (cfg_done) begin
                state_n    = ST_IDLE;
                force_pend = 1'b1;       // write the committed level once
            end
            ST_IDLE: if (pending) begin
                clr_pend = 1'b1;
                idx_clr  = 1'b1;
                state_n  = ST_LOAD;
            end
            ST_LOAD: begin
                ld_data   = 1'b1;
                retry_clr = 1'b1;
                state_n   = ST_EXEC;
            end
            ST_EXEC: state_n = ST_WAIT;
            ST_WAIT: if (bus.i2c_done) begin
                if (!bus.i2c_ack) begin
                    state_n = ST_NEXT;
                end else if (retry_cnt < MAX_RETRY) begin
                    retry_inc = 1'b1;
                    state_n   = ST_EXEC;  // resend the same word
                end else begin
                    set_err = 1'b1;       // give up on this register
                    state_n = ST_NEXT;
                end
            end
            ST_NEXT: if (idx == LAST_IDX) begin
                state_n = ST_IDLE;
            end else begin
                idx_inc = 1'b1;
                state_n = ST_LOAD;
            end
            default: state_n = ST_WAIT_CFG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_WAIT_CFG;
        // NOTE: clocked state always uses <=, so every register samples pre-edge values.
        else     state <= state_n;
    end

    // Requests apply in any state. A request that arrives while a sequence
    // is running only changes later LOADs. pending then schedules one more
    // full sequence, and repeated requests merge into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vol_level    <= VOL_INIT;
            mute         <= 1'b0;
            pending      <= 1'b0;
            idx          <= 2'd0;
            retry_cnt    <= 2'd0;
            bus.i2c_data <= 16'd0;
            err          <= 1'b0;
        end else begin
            vol_level <= next_level(vol_level, VOL_STEP, vol_up, vol_dn);
            mute      <= mute ^ mute_tgl;

            // A new request wins over the clear in IDLE, so it is not lost.
            if (force_pend || req) pending <= 1'b1;
            else if (clr_pend)     pending <= 1'b0;

            if (idx_clr)      idx <= 2'd0;
            else if (idx_inc) idx <= idx + 2'd1;

            if (retry_clr)      retry_cnt <= 2'd0;
            else if (retry_inc) retry_cnt <= retry_cnt + 2'd1;

            // The word is captured only in LOAD. It stays stable through
            // EXEC/WAIT and across retries.
            if (ld_data) bus.i2c_data <= reg_word(idx, mute, vol_level);

            if (set_err) err <= 1'b1;
        end
    end

    assign bus.i2c_exec = (state == ST_EXEC);
    assign busy         = (state != ST_IDLE) && (state != ST_WAIT_CFG);

endmodule
